tetromino_rotate_ctrl: RTL and testbench

TETROMINO_ROTATE_CTRL -- requirements
Module: tetromino_rotate_ctrl

---
 rtl/tetromino_rotate_ctrl_if.sv | 25 ++
 rtl/tetromino_rotate_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_tetromino_rotate_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetromino_rotate_ctrl_if.sv
// Kick-offset datum query and collision-check handshake between the rotation
// controller (master) and the board logic (slave).
interface tetromino_rotate_ctrl_if;
    logic [3:0] dat_piece;
    logic [1:0] dat_rot;
    logic [2:0] dat_idx;
    logic [3:0] dat_x_off;
    logic [5:0] dat_y_off;
    logic       chk_req;
    logic [3:0] chk_x;
    logic [5:0] chk_y;
    logic [1:0] chk_rot;
    logic       chk_ack;
    logic       chk_ok;

    modport master (
        output dat_piece, dat_rot, dat_idx, chk_req, chk_x, chk_y, chk_rot,
        input  dat_x_off, dat_y_off, chk_ack, chk_ok
    );

    modport slave (
        input  dat_piece, dat_rot, dat_idx, chk_req, chk_x, chk_y, chk_rot,
        output dat_x_off, dat_y_off, chk_ack, chk_ok
    );
endinterface

// File: rtl/tetromino_rotate_ctrl.sv
// Rotation controller: walks the wall-kick test list, querying from/to datum
// offsets and asking the board for a collision check on each in-bounds candidate.
module tetromino_rotate_ctrl #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 40
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rot_req,
    input  logic                          rot_dir,
    input  logic [3:0]                    piece,
    input  logic [1:0]                    cur_rot,
    input  logic [3:0]                    pos_x,
    input  logic [5:0]                    pos_y,
    tetromino_rotate_ctrl_if.master       bus,
    output logic                          busy,
    output logic                          done,
    output logic                          success,
    output logic [3:0]                    new_x,
    output logic [5:0]                    new_y,
    output logic [1:0]                    new_rot,
    output logic [2:0]                    kick_idx
);

    localparam logic [4:0] X_LIM = 5'(BOARD_W);
    localparam logic [6:0] Y_LIM = 7'(BOARD_H);
    localparam logic [3:0] PIECE_O = 4'd4;
    localparam logic [3:0] PIECE_MAX = 4'd7;

    typedef enum logic [2:0] {IDLE, LOOK_FROM, LOOK_TO, CHECK, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  piece_q, piece_d;
    logic [1:0]  rot_q, rot_d, tgt_q, tgt_d;
    logic [3:0]  px_q, px_d, fx_q, fx_d, cx_q, cx_d;
    logic [5:0]  py_q, py_d, fy_q, fy_d, cy_q, cy_d;
    logic [2:0]  idx_q, idx_d, last_q, last_d;
    logic        inb_q, inb_d;
    logic [3:0]  dat_piece_q, dat_piece_d;
    logic [1:0]  dat_rot_q, dat_rot_d;
    logic [2:0]  dat_idx_q, dat_idx_d;
    logic        chk_req_q, chk_req_d;
    logic        busy_d, done_d, success_d;
    logic [3:0]  new_x_d;
    logic [5:0]  new_y_d;
    logic [1:0]  new_rot_d;
    logic [2:0]  kick_idx_d;

    logic signed [4:0] kick_x;
    logic signed [6:0] kick_y;
    logic signed [5:0] cand_x;
    logic signed [7:0] cand_y;
    logic              cand_inb;

    // Kick = from_offset - to_offset; the to_offset is the live datum response in LOOK_TO.
    assign kick_x   = $signed({fx_q[3], fx_q}) - $signed({bus.dat_x_off[3], bus.dat_x_off});
    assign kick_y   = $signed({fy_q[5], fy_q}) - $signed({bus.dat_y_off[5], bus.dat_y_off});
    assign cand_x   = $signed({2'b00, px_q}) + $signed({kick_x[4], kick_x});
    assign cand_y   = $signed({2'b00, py_q}) + $signed({kick_y[6], kick_y});
    assign cand_inb = !cand_x[5] && (cand_x[4:0] < X_LIM) && !cand_y[7] && (cand_y[6:0] < Y_LIM);

    assign bus.dat_piece = dat_piece_q;
    assign bus.dat_rot   = dat_rot_q;
    assign bus.dat_idx   = dat_idx_q;
    assign bus.chk_req   = chk_req_q;
    assign bus.chk_x     = cx_q;
    assign bus.chk_y     = cy_q;
    assign bus.chk_rot   = tgt_q;

    always_comb begin
        state_d    = state_q;
        piece_d    = piece_q;
        rot_d      = rot_q;
        tgt_d      = tgt_q;
        px_d       = px_q;
        py_d       = py_q;
        idx_d      = idx_q;
        last_d     = last_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        inb_d      = inb_q;
        dat_piece_d = '0;
        dat_rot_d  = '0;
        dat_idx_d  = '0;
        chk_req_d  = 1'b0;
        done_d     = 1'b0;
        success_d  = success;
        new_x_d    = new_x;
        new_y_d    = new_y;
        new_rot_d  = new_rot;
        kick_idx_d = kick_idx;

        case (state_q)
            IDLE: begin
                if (rot_req) begin
                    piece_d = piece;
                    rot_d   = cur_rot;
                    tgt_d   = rot_dir ? cur_rot - 2'd1 : cur_rot + 2'd1;
                    px_d    = pos_x;
                    py_d    = pos_y;
                    idx_d   = 3'd0;
                    last_d  = (piece == PIECE_O) ? 3'd0 : 3'd4;
                    if (piece == 4'd0 || piece > PIECE_MAX) begin
                        // Unknown piece: report failure without touching the board.
                        state_d    = DONE;
                        success_d  = 1'b0;
                        new_x_d    = pos_x;
                        new_y_d    = pos_y;
                        new_rot_d  = cur_rot;
                        kick_idx_d = 3'd4;
                    end else begin
                        state_d     = LOOK_FROM;
                        dat_piece_d = piece;
                        dat_rot_d   = cur_rot;
                        dat_idx_d   = 3'd0;
                    end
                end
            end
            LOOK_FROM: begin
                fx_d        = bus.dat_x_off;
                fy_d        = bus.dat_y_off;
                state_d     = LOOK_TO;
                dat_piece_d = piece_q;
                dat_rot_d   = tgt_q;
                dat_idx_d   = idx_q;
            end
            LOOK_TO: begin
                cx_d      = cand_x[3:0];
                cy_d      = cand_y[5:0];
                inb_d     = cand_inb;
                chk_req_d = cand_inb;
                state_d   = CHECK;
            end
            CHECK: begin
                // An out-of-bounds candidate is resolved as an immediate reject.
                if (!inb_q || bus.chk_ack) begin
                    if (inb_q && bus.chk_ok) begin
                        state_d    = DONE;
                        success_d  = 1'b1;
                        new_x_d    = cx_q;
                        new_y_d    = cy_q;
                        new_rot_d  = tgt_q;
                        kick_idx_d = idx_q;
                    end else if (idx_q != last_q) begin
                        idx_d       = idx_q + 3'd1;
                        state_d     = LOOK_FROM;
                        dat_piece_d = piece_q;
                        dat_rot_d   = rot_q;
                        dat_idx_d   = idx_q + 3'd1;
                    end else begin
                        state_d    = DONE;
                        success_d  = 1'b0;
                        new_x_d    = px_q;
                        new_y_d    = py_q;
                        new_rot_d  = rot_q;
                        kick_idx_d = last_q;
                    end
                end else begin
                    chk_req_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            piece_q     <= '0;
            rot_q       <= '0;
            tgt_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            inb_q       <= 1'b0;
            dat_piece_q <= '0;
            dat_rot_q   <= '0;
            dat_idx_q   <= '0;
            chk_req_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            success     <= 1'b0;
            new_x       <= '0;
            new_y       <= '0;
            new_rot     <= '0;
            kick_idx    <= '0;
        end else begin
            state_q     <= state_d;
            piece_q     <= piece_d;
            rot_q       <= rot_d;
            tgt_q       <= tgt_d;
            px_q        <= px_d;
            py_q        <= py_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            inb_q       <= inb_d;
            dat_piece_q <= dat_piece_d;
            dat_rot_q   <= dat_rot_d;
            dat_idx_q   <= dat_idx_d;
            chk_req_q   <= chk_req_d;
            busy        <= busy_d;
            done        <= done_d;
            success     <= success_d;
            new_x       <= new_x_d;
            new_y       <= new_y_d;
            new_rot     <= new_rot_d;
            kick_idx    <= kick_idx_d;
        end
    end

endmodule

// File: tb/tb_tetromino_rotate_ctrl.sv
// Bench for tetromino_rotate_ctrl: SRS datum table and collision responder
// around the DUT, directed vectors plus randomized requests against a kick-list model.
module tb_tetromino_rotate_ctrl;

    logic       clk;
    logic       reset_n;
    logic       rot_req;
    logic       rot_dir;
    logic [3:0] piece;
    logic [1:0] cur_rot;
    logic [3:0] pos_x;
    logic [5:0] pos_y;
    logic       busy;
    logic       done;
    logic       success;
    logic [3:0] new_x;
    logic [5:0] new_y;
    logic [1:0] new_rot;
    logic [2:0] kick_idx;

    tetromino_rotate_ctrl_if bus();

    tetromino_rotate_ctrl #(.BOARD_W(10), .BOARD_H(40)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rot_req  (rot_req),
        .rot_dir  (rot_dir),
        .piece    (piece),
        .cur_rot  (cur_rot),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .success  (success),
        .new_x    (new_x),
        .new_y    (new_y),
        .new_rot  (new_rot),
        .kick_idx (kick_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRS offset data: rows are rotation 0,R,2,L; columns are test index 0..4.
    int jlstz_x [4][5] = '{'{0,0,0,0,0}, '{0,1,1,0,1}, '{0,0,0,0,0}, '{0,-1,-1,0,-1}};
    int jlstz_y [4][5] = '{'{0,0,0,0,0}, '{0,0,-1,2,2}, '{0,0,0,0,0}, '{0,0,-1,2,2}};
    int ipc_x   [4][5] = '{'{0,-1,2,-1,2}, '{-1,0,0,0,0}, '{-1,1,-2,1,-2}, '{0,0,0,0,0}};
    int ipc_y   [4][5] = '{'{0,0,0,0,0}, '{0,0,0,1,-2}, '{1,1,1,0,0}, '{1,1,1,-1,2}};
    int opc_x   [4]    = '{0,0,-1,-1};
    int opc_y   [4]    = '{0,-1,-1,0};

    function automatic int offx(input int pc, input int r, input int i);
        if (i > 4) return 0;
        case (pc)
            3:             return ipc_x[r][i];
            4:             return (i == 0) ? opc_x[r] : 0;
            1, 2, 5, 6, 7: return jlstz_x[r][i];
            default:       return 0;
        endcase
    endfunction

    function automatic int offy(input int pc, input int r, input int i);
        if (i > 4) return 0;
        case (pc)
            3:             return ipc_y[r][i];
            4:             return (i == 0) ? opc_y[r] : 0;
            1, 2, 5, 6, 7: return jlstz_y[r][i];
            default:       return 0;
        endcase
    endfunction

    always_comb begin
        bus.dat_x_off = 4'(offx(int'(bus.dat_piece), int'(bus.dat_rot), int'(bus.dat_idx)));
        bus.dat_y_off = 6'(offy(int'(bus.dat_piece), int'(bus.dat_rot), int'(bus.dat_idx)));
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: walks the test list and predicts board requests and result.
    int m_succ, m_x, m_y, m_rot, m_kidx, m_lat, m_tgt, m_np;
    int eq_x[$];
    int eq_y[$];
    int wq[5];

    task automatic model(input int pc, input int r, input int d, input int px, input int py, input int k);
        int n, cnt, cx, cy;
        eq_x.delete();
        eq_y.delete();
        m_tgt = (r + (d != 0 ? 3 : 1)) % 4;
        m_succ = 0; m_x = px; m_y = py; m_rot = r; m_kidx = 4; m_lat = 1;
        if (pc >= 1 && pc <= 7) begin
            n = (pc == 4) ? 1 : 5;
            cnt = 0;
            for (int i = 0; i < n; i++) begin
                m_lat += 3;
                cx = px + offx(pc, r, i) - offx(pc, m_tgt, i);
                cy = py + offy(pc, r, i) - offy(pc, m_tgt, i);
                if (cx >= 0 && cx < 10 && cy >= 0 && cy < 40) begin
                    eq_x.push_back(cx);
                    eq_y.push_back(cy);
                    m_lat += wq[cnt];
                    if (cnt == k) begin
                        m_succ = 1; m_x = cx; m_y = cy; m_rot = m_tgt; m_kidx = i;
                        break;
                    end
                    cnt++;
                end
            end
            if (m_succ == 0) m_kidx = n - 1;
        end
        m_np = eq_x.size();
    endtask

    task automatic run_txn(input string nm, input int pc, input int r, input int d,
                           input int px, input int py, input int k,
                           input int e_succ, input int e_x, input int e_y, input int e_rot,
                           input int e_kidx, input int e_lat, input int e_fx, input int e_fy);
        int  cyc, pulses, wcnt, pidx;
        bit  prev, got;
        model(pc, r, d, px, py, k);
        @(negedge clk);
        piece = 4'(pc); cur_rot = 2'(r); rot_dir = 1'(d);
        pos_x = 4'(px); pos_y = 6'(py); rot_req = 1'b1;
        @(posedge clk);
        cyc = 0; pulses = 0; prev = 1'b0; got = 1'b0; wcnt = 0; pidx = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            rot_req = 1'b0;
            bus.chk_ack = 1'b0;
            bus.chk_ok = 1'($urandom_range(0, 1));
            // Stray requests and input churn while busy must have no effect.
            if (busy && $urandom_range(0, 3) == 0) begin
                rot_req = 1'b1;
                piece   = 4'($urandom_range(0, 15));
                cur_rot = 2'($urandom_range(0, 3));
                rot_dir = 1'($urandom_range(0, 1));
                pos_x   = 4'($urandom_range(0, 15));
                pos_y   = 6'($urandom_range(0, 63));
            end
            if (cyc == 0) check({nm, "_busy"}, 32'(busy), 1);
            if (bus.chk_req) begin
                if (!prev) begin
                    pidx = pulses;
                    pulses++;
                    if (eq_x.size() > 0) begin
                        check({nm, "_chk_x"}, 32'(bus.chk_x), eq_x.pop_front());
                        check({nm, "_chk_y"}, 32'(bus.chk_y), eq_y.pop_front());
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL %s_extra_chk_req: got pulse %0d, expected %0d pulses", nm, pulses, m_np);
                    end
                    check({nm, "_chk_rot"}, 32'(bus.chk_rot), m_tgt);
                    if (pidx == 0 && e_fx >= 0) begin
                        check({nm, "_first_x"}, 32'(bus.chk_x), e_fx);
                        check({nm, "_first_y"}, 32'(bus.chk_y), e_fy);
                    end
                    wcnt = (pidx < 5) ? wq[pidx] : 0;
                end
                if (wcnt == 0) begin
                    bus.chk_ack = 1'b1;
                    bus.chk_ok = (pidx == k);
                end else begin
                    wcnt--;
                end
            end
            prev = bus.chk_req;
            if (done) begin
                got = 1'b1;
                check({nm, "_success"}, 32'(success), e_succ);
                check({nm, "_new_x"}, 32'(new_x), e_x);
                check({nm, "_new_y"}, 32'(new_y), e_y);
                check({nm, "_new_rot"}, 32'(new_rot), e_rot);
                check({nm, "_kick_idx"}, 32'(kick_idx), e_kidx);
                check({nm, "_latency"}, 32'(cyc), e_lat);
                check({nm, "_busy_at_done"}, 32'(busy), 0);
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done at %0d", nm, cyc, e_lat);
        end
        check({nm, "_pulses"}, 32'(pulses), m_np);
        @(posedge clk);
        @(negedge clk);
        rot_req = 1'b0;
        bus.chk_ack = 1'b0;
        check({nm, "_done_width"}, 32'(done), 0);
        check({nm, "_idle_busy"}, 32'(busy), 0);
        check({nm, "_idle_dat"}, 32'({bus.dat_piece, bus.dat_rot, bus.dat_idx}), 0);
        check({nm, "_idle_chk_req"}, 32'(bus.chk_req), 0);
    endtask

    typedef struct {
        int pc, r, d, px, py, k;
        int succ, x, y, rot, kidx, lat, fx, fy;
    } vec_t;

    vec_t vt[11];

    initial begin
        // piece, rot, dir, x, y, accept-pulse | success, new x, y, rot, kick_idx, latency, first chk x, y
        vt[0]  = '{7, 0, 0, 4, 20, 0,  1, 4, 20, 1, 0, 4,  4, 20};
        vt[1]  = '{7, 0, 0, 4, 20, 1,  1, 3, 20, 1, 1, 7,  4, 20};
        vt[2]  = '{3, 0, 0, 4, 20, 0,  1, 5, 20, 1, 0, 4,  5, 20};
        vt[3]  = '{4, 0, 0, 4, 20, 9,  0, 4, 20, 0, 0, 4,  4, 21};
        vt[4]  = '{7, 0, 0, 0, 20, 1,  1, 0, 18, 1, 3, 13, 0, 20};
        vt[5]  = '{1, 2, 1, 4, 20, 9,  0, 4, 20, 2, 4, 16, 4, 20};
        vt[6]  = '{0, 0, 0, 4, 20, 0,  0, 4, 20, 0, 4, 1,  -1, -1};
        vt[7]  = '{9, 3, 0, 4, 20, 0,  0, 4, 20, 3, 4, 1,  -1, -1};
        vt[8]  = '{3, 0, 0, 9, 0,  0,  1, 8, 0,  1, 1, 7,  8, 0};
        vt[9]  = '{7, 1, 1, 5, 39, 9,  0, 5, 39, 1, 4, 16, 5, 39};
        vt[10] = '{7, 0, 0, 5, 0,  9,  0, 5, 0,  0, 4, 16, 5, 0};

        reset_n = 1'b0;
        rot_req = 1'b0; rot_dir = 1'b0; piece = '0; cur_rot = '0; pos_x = '0; pos_y = '0;
        bus.chk_ack = 1'b0; bus.chk_ok = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_chk_req", 32'(bus.chk_req), 0);
        check("rst_results", 32'({success, new_x, new_y, new_rot, kick_idx}), 0);
        check("rst_dat", 32'({bus.dat_piece, bus.dat_rot, bus.dat_idx}), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) wq[i] = 0;
        for (int v = 0; v < 11; v++) begin
            run_txn($sformatf("vec%0d", v), vt[v].pc, vt[v].r, vt[v].d, vt[v].px, vt[v].py, vt[v].k,
                    vt[v].succ, vt[v].x, vt[v].y, vt[v].rot, vt[v].kidx, vt[v].lat, vt[v].fx, vt[v].fy);
        end

        // Reset in the middle of a check, then a late acknowledge.
        begin
            int n;
            @(negedge clk);
            piece = 4'd7; cur_rot = 2'd0; rot_dir = 1'b0; pos_x = 4'd4; pos_y = 6'd20; rot_req = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rot_req = 1'b0;
            n = 0;
            while (!bus.chk_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("mid_rst_reach_check", 32'(bus.chk_req), 1);
            #2 reset_n = 1'b0;
            #1;
            check("mid_rst_chk_req", 32'(bus.chk_req), 0);
            check("mid_rst_busy", 32'(busy), 0);
            check("mid_rst_done", 32'(done), 0);
            bus.chk_ack = 1'b1;
            bus.chk_ok = 1'b1;
            @(negedge clk);
            check("mid_rst_hold_done", 32'(done), 0);
            reset_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("post_rst_busy", 32'(busy), 0);
                check("post_rst_done", 32'(done), 0);
                check("post_rst_chk_req", 32'(bus.chk_req), 0);
            end
            bus.chk_ack = 1'b0;
        end
        run_txn("post_rst", 7, 0, 0, 4, 20, 0, 1, 4, 20, 1, 0, 4, 4, 20);

        for (int t = 0; t < 60; t++) begin
            int pc, r, d, px, py, k;
            pc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 7));
            r  = int'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 1));
            px = int'($urandom_range(0, 11));
            py = int'($urandom_range(0, 41));
            k  = int'($urandom_range(0, 5));
            for (int i = 0; i < 5; i++) wq[i] = int'($urandom_range(0, 2));
            model(pc, r, d, px, py, k);
            run_txn($sformatf("rnd%0d", t), pc, r, d, px, py, k,
                    m_succ, m_x, m_y, m_rot, m_kidx, m_lat, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
